instr_trace_buffer: RTL and testbench
=====================================

// Module: instr_trace_buffer
// PURPOSE
//   Downstream debug consumer of the CPU top level's PC / Instr / Estado outputs, clocked by CLOCK.
//   Records one (PC, Instr) pair per executed instruction of the Multiciclo core into a circular buffer.
//   The buffer is read back by index, in chronological order, for the board display / JTAG probe.
// PARAMETERS
//   DEPTH        16    entries; power of 2, >= 2
//   FETCH_STATE  4'd0  Estado encoding of the fetch state
//   STOP_ON_FULL 0     1: freeze when full; 0: overwrite the oldest entry
// PORTS
//   CLOCK    in   1        system clock (fast clock, same as CPU memory clock)
//   Reset    in   1        synchronous, active-high
//   Clear    in   1        synchronous flush of contents and flags (same effect as Reset)
//   Enable   in   1        arms new captures
//   PC       in   32       CPU program counter
//   Instr    in   32       CPU current instruction
//   Estado   in   4        CPU FSM state
//   RdIdx    in   AW       read index; AW = $clog2(DEPTH); 0 = oldest entry
//   RdPC     out  32       PC of entry RdIdx (registered)
//   RdInstr  out  32       Instr of entry RdIdx (registered)
//   Count    out  AW+1     valid entries, 0..DEPTH
//   Full     out  1        Count == DEPTH
//   Overflow out  1        sticky; set when an event is dropped or an entry is overwritten
// BEHAVIOUR
// - One clock: CLOCK; all state updates on posedge CLOCK.
// - Reset (synchronous, active-high), and equally Clear, force:
//   - outputs: Count=0, Full=0, Overflow=0, RdPC=0, RdInstr=0;
//   - internal: wr_ptr=0, FSM=ARMED, estado_q=4'hF.
//   - A pending half-capture is discarded; memory contents need not be cleared.
// - estado_q <= Estado every cycle.
//   - entry = (Estado==FETCH_STATE) && (estado_q!=FETCH_STATE).
//   - exit  = (estado_q==FETCH_STATE) && (Estado!=FETCH_STATE).
// - FSM:
//   - ARMED:
//     - on entry with Enable=1: latch pc_hold<=PC, go PENDING;
//     - entry with Enable=0: stay ARMED.
//   - PENDING:
//     - on exit: commit {pc_hold, Instr} at wr_ptr, go ARMED;
//     - a new entry before exit: re-latch pc_hold (the earlier one is lost silently);
//     - Enable dropping in PENDING does not abort the capture.
//   - exit and entry in the same cycle is impossible (4-bit state); no special case needed.
// - Commit rules:
//   - Count<DEPTH: write; wr_ptr<=wr_ptr+1 (mod DEPTH); Count+1.
//   - Count==DEPTH, STOP_ON_FULL=1: no write; Overflow<=1; pointer and Count unchanged.
//   - Count==DEPTH, STOP_ON_FULL=0: overwrite oldest; wr_ptr+1; Count stays DEPTH; Overflow<=1.
// - Read path:
//   - physical addr = (Count<DEPTH) ? RdIdx : (wr_ptr+RdIdx) mod DEPTH.
//   - RdPC / RdInstr are valid 1 CLOCK after RdIdx is applied.
//   - Reading at the same clock edge as a commit returns the pre-commit contents.
//   - RdIdx >= Count: returns stale data; no error flag.
// - Full is combinational from Count.
// - Overflow is cleared only by Reset or Clear.
// TESTING
// 1 Reset=1 two cycles -> Count=0, Full=0, Overflow=0, RdPC=0.
//   Release with Estado=0 and PC=0x00400000; exit after 2 cycles -> entry0 = {0x00400000, Instr}.
// 2 Run 5 fetches, PC=0x00400000+4k, Instr=0x00000013+k -> Count=5.
//   RdIdx=3 -> next cycle RdPC=0x0040000C, RdInstr=0x00000016.
// 3 DEPTH=16, STOP_ON_FULL=0, 20 fetches (k=0..19) -> Count=16, Full=1, Overflow=1.
//   RdIdx=0 -> RdPC=0x00400010 (k=4); RdIdx=15 -> RdPC=0x0040004C.
// 4 STOP_ON_FULL=1, 20 fetches -> Count=16, Overflow=1; RdIdx=15 -> RdPC=0x0040003C (k=15).
// 5 Enable=0 during 3 fetches, then Enable=1 -> Count unchanged for those 3 fetches.
//   Enable=0 asserted while PENDING -> that capture still commits.
// 6 Reset while PENDING (entered fetch, no exit) -> Count=0; the following exit commits nothing.
//   Clear mid-run -> same state as after Reset.

Source files
------------

// File: rtl/instr_trace_buffer.sv
// Circular trace of (PC, Instr) pairs, one per executed instruction, taken from the
// fetch-state transitions of the multicycle CPU and read back oldest-first by index.
module instr_trace_buffer #(
  parameter int         DEPTH        = 16,
  parameter logic [3:0] FETCH_STATE  = 4'd0,
  parameter bit         STOP_ON_FULL = 1'b0,
  localparam int        AW           = $clog2(DEPTH)
) (
  input  logic          CLOCK,
  input  logic          Reset,
  input  logic          Clear,
  input  logic          Enable,
  input  logic [31:0]   PC,
  input  logic [31:0]   Instr,
  input  logic [3:0]    Estado,
  input  logic [AW-1:0] RdIdx,
  output logic [31:0]   RdPC,
  output logic [31:0]   RdInstr,
  output logic [AW:0]   Count,
  output logic          Full,
  output logic          Overflow,
  output logic          dbg_state_o
);

  typedef enum logic {ARMED = 1'b0, PENDING = 1'b1} state_e;

  state_e        state_q;
  logic [3:0]    estado_q;
  logic [31:0]   pc_hold_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   rd_pc_q, rd_instr_q;
  logic [63:0]   mem_q [DEPTH];

  logic          flush, entry, exit_ev, full, commit, do_write;
  logic [AW-1:0] rd_addr;

  assign flush   = Reset | Clear;
  assign entry   = (Estado == FETCH_STATE) && (estado_q != FETCH_STATE);
  assign exit_ev = (estado_q == FETCH_STATE) && (Estado != FETCH_STATE);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign commit  = (state_q == PENDING) && exit_ev;

  // Once full, the oldest entry sits at wr_ptr; the AW-bit add wraps modulo DEPTH.
  assign rd_addr = full ? (wr_ptr_q + RdIdx) : RdIdx;

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    do_write   = 1'b0;
    if (commit) begin
      if (!full) begin
        do_write = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + (AW+1)'(1);
      end else begin
        overflow_d = 1'b1;
        if (!STOP_ON_FULL) begin
          do_write = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (flush) begin
      state_q    <= ARMED;
      estado_q   <= 4'hF;
      pc_hold_q  <= 32'd0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_pc_q    <= 32'd0;
      rd_instr_q <= 32'd0;
    end else begin
      estado_q   <= Estado;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_pc_q    <= mem_q[rd_addr][63:32];
      rd_instr_q <= mem_q[rd_addr][31:0];
      case (state_q)
        ARMED: begin
          if (entry && Enable) begin
            pc_hold_q <= PC;
            state_q   <= PENDING;
          end
        end
        PENDING: begin
          // Enable is ignored here: a capture that has started always completes.
          if (exit_ev) begin
            state_q <= ARMED;
          end else if (entry) begin
            pc_hold_q <= PC;
          end
        end
        default: state_q <= ARMED;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (do_write && !flush) begin
      mem_q[wr_ptr_q] <= {pc_hold_q, Instr};
    end
  end

  assign RdPC        = rd_pc_q;
  assign RdInstr     = rd_instr_q;
  assign Count       = count_q;
  assign Full        = full;
  assign Overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Directed bench for instr_trace_buffer: one overwrite instance and one stop-on-full
// instance driven by the same CPU-state stimulus.
module tb_instr_trace_buffer;

  logic        CLOCK = 1'b0;
  logic        Reset, Clear, Enable;
  logic [31:0] PC, Instr;
  logic [3:0]  Estado;
  logic [3:0]  RdIdx;

  logic [31:0] rd_pc0, rd_in0, rd_pc1, rd_in1;
  logic [4:0]  cnt0, cnt1;
  logic        full0, full1, ovf0, ovf1, dbg0, dbg1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLOCK = ~CLOCK;

  instr_trace_buffer #(.DEPTH(16), .FETCH_STATE(4'd0), .STOP_ON_FULL(1'b0)) dut0 (
    .CLOCK(CLOCK), .Reset(Reset), .Clear(Clear), .Enable(Enable), .PC(PC), .Instr(Instr),
    .Estado(Estado), .RdIdx(RdIdx), .RdPC(rd_pc0), .RdInstr(rd_in0), .Count(cnt0),
    .Full(full0), .Overflow(ovf0), .dbg_state_o(dbg0)
  );

  instr_trace_buffer #(.DEPTH(16), .FETCH_STATE(4'd0), .STOP_ON_FULL(1'b1)) dut1 (
    .CLOCK(CLOCK), .Reset(Reset), .Clear(Clear), .Enable(Enable), .PC(PC), .Instr(Instr),
    .Estado(Estado), .RdIdx(RdIdx), .RdPC(rd_pc1), .RdInstr(rd_in1), .Count(cnt1),
    .Full(full1), .Overflow(ovf1), .dbg_state_o(dbg1)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset();
    Estado = 4'd2;
    Reset  = 1'b1;
    step();
    step();
    Reset  = 1'b0;
  endtask

  // One instruction: a cycle in fetch, then a cycle in a later state carrying Instr.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] ins);
    Estado = 4'd0;
    PC     = pc;
    Instr  = 32'hDEAD_BEEF;
    step();
    Estado = 4'd1;
    Instr  = ins;
    step();
  endtask

  task automatic read_at(input logic [3:0] idx);
    RdIdx = idx;
    step();
  endtask

  task automatic test_reset();
    Estado = 4'd2;
    Reset  = 1'b1;
    step();
    step();
    n_cmp++; if (cnt0 !== 5'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
    n_cmp++; if (full0 !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b exp=0", full0); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", ovf0); end
    n_cmp++; if (rd_pc0 !== 32'd0) begin n_bad++; $display("FAIL reset_rdpc got=%h exp=0", rd_pc0); end
    Reset  = 1'b0;
    Estado = 4'd0;
    PC     = 32'h0040_0000;
    step();
    step();
    Estado = 4'd1;
    Instr  = 32'h0000_0013;
    step();
    Estado = 4'd2;
    n_cmp++; if (cnt0 !== 5'd1) begin n_bad++; $display("FAIL first_count got=%0d exp=1", cnt0); end
    read_at(4'd0);
    n_cmp++; if (rd_pc0 !== 32'h0040_0000) begin n_bad++; $display("FAIL first_pc got=%h exp=00400000", rd_pc0); end
    n_cmp++; if (rd_in0 !== 32'h0000_0013) begin n_bad++; $display("FAIL first_instr got=%h exp=00000013", rd_in0); end
  endtask

  task automatic test_five();
    do_reset();
    for (int k = 0; k < 5; k++) do_fetch(32'h0040_0000 + 32'(4*k), 32'h0000_0013 + 32'(k));
    Estado = 4'd2;
    n_cmp++; if (cnt0 !== 5'd5) begin n_bad++; $display("FAIL five_count got=%0d exp=5", cnt0); end
    read_at(4'd3);
    n_cmp++; if (rd_pc0 !== 32'h0040_000C) begin n_bad++; $display("FAIL five_pc3 got=%h exp=0040000c", rd_pc0); end
    n_cmp++; if (rd_in0 !== 32'h0000_0016) begin n_bad++; $display("FAIL five_instr3 got=%h exp=00000016", rd_in0); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 16; k++) do_fetch(32'h0040_0000 + 32'(4*k), 32'h0000_0013 + 32'(k));
    n_cmp++; if (full0 !== 1'b1) begin n_bad++; $display("FAIL at16_full got=%b exp=1", full0); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL at16_ovf got=%b exp=0", ovf0); end
    for (int k = 16; k < 20; k++) do_fetch(32'h0040_0000 + 32'(4*k), 32'h0000_0013 + 32'(k));
    Estado = 4'd2;
    n_cmp++; if (cnt0 !== 5'd16) begin n_bad++; $display("FAIL wrap_count got=%0d exp=16", cnt0); end
    n_cmp++; if (ovf0 !== 1'b1) begin n_bad++; $display("FAIL wrap_ovf got=%b exp=1", ovf0); end
    n_cmp++; if (cnt1 !== 5'd16) begin n_bad++; $display("FAIL stop_count got=%0d exp=16", cnt1); end
    n_cmp++; if (full1 !== 1'b1) begin n_bad++; $display("FAIL stop_full got=%b exp=1", full1); end
    n_cmp++; if (ovf1 !== 1'b1) begin n_bad++; $display("FAIL stop_ovf got=%b exp=1", ovf1); end
    read_at(4'd0);
    n_cmp++; if (rd_pc0 !== 32'h0040_0010) begin n_bad++; $display("FAIL wrap_pc0 got=%h exp=00400010", rd_pc0); end
    n_cmp++; if (rd_in0 !== 32'h0000_0017) begin n_bad++; $display("FAIL wrap_instr0 got=%h exp=00000017", rd_in0); end
    n_cmp++; if (rd_pc1 !== 32'h0040_0000) begin n_bad++; $display("FAIL stop_pc0 got=%h exp=00400000", rd_pc1); end
    read_at(4'd15);
    n_cmp++; if (rd_pc0 !== 32'h0040_004C) begin n_bad++; $display("FAIL wrap_pc15 got=%h exp=0040004c", rd_pc0); end
    n_cmp++; if (rd_in0 !== 32'h0000_0026) begin n_bad++; $display("FAIL wrap_instr15 got=%h exp=00000026", rd_in0); end
    n_cmp++; if (rd_pc1 !== 32'h0040_003C) begin n_bad++; $display("FAIL stop_pc15 got=%h exp=0040003c", rd_pc1); end
    n_cmp++; if (rd_in1 !== 32'h0000_0022) begin n_bad++; $display("FAIL stop_instr15 got=%h exp=00000022", rd_in1); end
  endtask

  task automatic test_enable();
    do_reset();
    Enable = 1'b0;
    for (int k = 0; k < 3; k++) do_fetch(32'h0040_0000 + 32'(4*k), 32'h0000_0013 + 32'(k));
    n_cmp++; if (cnt0 !== 5'd0) begin n_bad++; $display("FAIL en_off_count got=%0d exp=0", cnt0); end
    Enable = 1'b1;
    do_fetch(32'h0040_0100, 32'h0000_0100);
    n_cmp++; if (cnt0 !== 5'd1) begin n_bad++; $display("FAIL en_on_count got=%0d exp=1", cnt0); end
    Estado = 4'd0;
    PC     = 32'h0040_0200;
    step();
    n_cmp++; if (dbg0 !== 1'b1) begin n_bad++; $display("FAIL en_pending got=%b exp=1", dbg0); end
    Enable = 1'b0;
    Estado = 4'd1;
    Instr  = 32'h0000_0200;
    step();
    Estado = 4'd2;
    n_cmp++; if (cnt0 !== 5'd2) begin n_bad++; $display("FAIL en_drop_count got=%0d exp=2", cnt0); end
    Enable = 1'b1;
    read_at(4'd1);
    n_cmp++; if (rd_pc0 !== 32'h0040_0200) begin n_bad++; $display("FAIL en_drop_pc got=%h exp=00400200", rd_pc0); end
    n_cmp++; if (rd_in0 !== 32'h0000_0200) begin n_bad++; $display("FAIL en_drop_instr got=%h exp=00000200", rd_in0); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    Estado = 4'd0;
    PC     = 32'h0040_0300;
    step();
    n_cmp++; if (dbg0 !== 1'b1) begin n_bad++; $display("FAIL rp_pending got=%b exp=1", dbg0); end
    Reset = 1'b1;
    step();
    Reset  = 1'b0;
    Estado = 4'd1;
    Instr  = 32'h0000_0300;
    step();
    Estado = 4'd2;
    step();
    n_cmp++; if (cnt0 !== 5'd0) begin n_bad++; $display("FAIL rp_count got=%0d exp=0", cnt0); end
    n_cmp++; if (dbg0 !== 1'b0) begin n_bad++; $display("FAIL rp_state got=%b exp=0", dbg0); end
  endtask

  task automatic test_clear();
    do_reset();
    for (int k = 0; k < 20; k++) do_fetch(32'h0040_0000 + 32'(4*k), 32'h0000_0013 + 32'(k));
    n_cmp++; if (ovf0 !== 1'b1) begin n_bad++; $display("FAIL clr_pre_ovf got=%b exp=1", ovf0); end
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    n_cmp++; if (cnt0 !== 5'd0) begin n_bad++; $display("FAIL clr_count got=%0d exp=0", cnt0); end
    n_cmp++; if (full0 !== 1'b0) begin n_bad++; $display("FAIL clr_full got=%b exp=0", full0); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL clr_ovf got=%b exp=0", ovf0); end
    n_cmp++; if (rd_pc0 !== 32'd0) begin n_bad++; $display("FAIL clr_rdpc got=%h exp=0", rd_pc0); end
    n_cmp++; if (cnt1 !== 5'd0) begin n_bad++; $display("FAIL clr_count1 got=%0d exp=0", cnt1); end
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL clr_ovf1 got=%b exp=0", ovf1); end
    Estado = 4'd2;
    step();
    do_fetch(32'h0040_0500, 32'h0000_0055);
    Estado = 4'd2;
    read_at(4'd0);
    n_cmp++; if (cnt0 !== 5'd1) begin n_bad++; $display("FAIL clr_after_count got=%0d exp=1", cnt0); end
    n_cmp++; if (rd_pc0 !== 32'h0040_0500) begin n_bad++; $display("FAIL clr_after_pc got=%h exp=00400500", rd_pc0); end
  endtask

  initial begin
    Reset  = 1'b1;
    Clear  = 1'b0;
    Enable = 1'b1;
    PC     = 32'd0;
    Instr  = 32'd0;
    Estado = 4'd2;
    RdIdx  = 4'd0;
    test_reset();
    test_five();
    test_wrap();
    test_enable();
    test_reset_pending();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
